// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared widths, reset PC, branch-history counter encoding and
// the saturating counter step used by the branch history table.
package pc_gen_pkg;

    localparam int          XLEN             = 32;
    localparam int          PC_WIDTH         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // 2-bit saturating counter states; bit 1 set means "predict taken".
    typedef enum logic [1:0] {
        BHT_SNT = 2'd0,
        BHT_WNT = 2'd1,
        BHT_WT  = 2'd2,
        BHT_ST  = 2'd3
    } bht_cnt_e;

    // One training step: move toward the observed outcome, clamp at the ends.
    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != BHT_ST) nxt = bht_cnt_e'(cur + 2'd1);
        end else begin
            if (cur != BHT_SNT) nxt = bht_cnt_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: bundle of fetch mini-decode, execute feedback and fetch-PC
// signals around the PC generator.
//   master : fetch/decode/execute side (drives jump, stall, redirect, training)
//   slave  : pc_gen (drives F_PC_o, F_pred_taken_o, mispredict_cnt_o)
// There is no valid/ready handshake: D_stall_i is a level hold request, and
// E_redirect_i / E_branch_valid_i are single-cycle qualifiers sampled on
// every rising clock edge.
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic                F_jmp_sel_i;
    logic                F_jmp_is_branch_i;
    logic [PC_WIDTH-1:0] F_jmp_i;
    logic                D_stall_i;
    logic                E_redirect_i;
    logic [PC_WIDTH-1:0] E_redirect_pc_i;
    logic                E_branch_valid_i;
    logic [PC_WIDTH-1:0] E_branch_pc_i;
    logic                E_branch_taken_i;
    logic [PC_WIDTH-1:0] F_PC_o;
    logic                F_pred_taken_o;
    logic [31:0]         mispredict_cnt_o;

    modport master (
        output F_jmp_sel_i, F_jmp_is_branch_i, F_jmp_i, D_stall_i,
               E_redirect_i, E_redirect_pc_i,
               E_branch_valid_i, E_branch_pc_i, E_branch_taken_i,
        input  F_PC_o, F_pred_taken_o, mispredict_cnt_o
    );

    modport slave (
        input  F_jmp_sel_i, F_jmp_is_branch_i, F_jmp_i, D_stall_i,
               E_redirect_i, E_redirect_pc_i,
               E_branch_valid_i, E_branch_pc_i, E_branch_taken_i,
        output F_PC_o, F_pred_taken_o, mispredict_cnt_o
    );

endinterface

// File: rtl/pc_gen_bht.sv
// pc_gen_bht: branch history table of ENTRIES 2-bit saturating counters.
//   clk_i, rst_n_i : clock, async active-low reset (all counters -> weak-NT)
//   rd_idx_i       : combinational lookup index
//   rd_cnt_o       : counter at rd_idx_i (pre-update value, no bypass)
//   upd_en_i       : train the counter at upd_idx_i this cycle
//   upd_idx_i      : index to train
//   upd_taken_i    : resolved outcome
module pc_gen_bht
    import pc_gen_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_cnt_e         rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_cnt_e cnt_q [ENTRIES];

    // Read is the registered value, so a same-cycle update to the same
    // index becomes visible only from the next cycle.
    assign rd_cnt_o = cnt_q[rd_idx_i];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_WNT;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register and next-PC selection.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus (slave)    : mini-decode jump info, stall, execute redirect and
//                    branch training in; fetch PC, prediction flag and
//                    mispredict count out
// Next-PC priority: redirect > stall (hold) > predicted jump > PC+4.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int                  BHT_ENTRIES = 16
) (
    input logic     clk_i,
    input logic     rst_n_i,
    pc_gen_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [31:0]         mis_cnt_q;
    bht_cnt_e            lookup_cnt;
    logic                pred_taken;

    pc_gen_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_idx_i    (pc_q[2 +: IDX_W]),
        .rd_cnt_o    (lookup_cnt),
        .upd_en_i    (bus.E_branch_valid_i),
        .upd_idx_i   (bus.E_branch_pc_i[2 +: IDX_W]),
        .upd_taken_i (bus.E_branch_taken_i)
    );

    // jal is always taken; a conditional branch follows the counter's MSB.
    // Redirect or stall suppresses the prediction since the target won't be used.
    always_comb begin
        pred_taken = bus.F_jmp_sel_i
                   & (~bus.F_jmp_is_branch_i | lookup_cnt[1])
                   & ~bus.E_redirect_i & ~bus.D_stall_i;
    end

    always_comb begin
        pc_d = pc_q + PC_WIDTH'(4);
        if (bus.E_redirect_i)   pc_d = bus.E_redirect_pc_i;
        else if (bus.D_stall_i) pc_d = pc_q;
        else if (pred_taken)    pc_d = bus.F_jmp_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q      <= RESET_PC;
            mis_cnt_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (bus.E_redirect_i) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign bus.F_PC_o           = pc_q;
    assign bus.F_pred_taken_o   = pred_taken;
    assign bus.mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed walk through the PC generator's behaviours followed by
// random traffic, all checked against a reference model built from integer
// arithmetic (PC, per-index counter array, redirect count).
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam int          ENTRIES = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // reference model state
    logic [31:0] pc_m;
    logic [31:0] mis_m;
    int          bht_m [ENTRIES];

    pc_gen_if ifc ();

    pc_gen #(
        .RESET_PC    (RST_PC),
        .BHT_ENTRIES (ENTRIES)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        pc_m  = RST_PC;
        mis_m = 32'd0;
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; check outputs, advance one clock, update model.
    task automatic step();
        logic        pred_m;
        logic [31:0] next_m;
        int          k;
        #2;
        pred_m = ifc.F_jmp_sel_i
               && (!ifc.F_jmp_is_branch_i || bht_m[idx_of(pc_m)] >= 2)
               && !ifc.E_redirect_i && !ifc.D_stall_i;
        chk("pc",   ifc.F_PC_o, pc_m);
        chk("pred", {31'd0, ifc.F_pred_taken_o}, {31'd0, pred_m});
        chk("mis",  ifc.mispredict_cnt_o, mis_m);
        if (ifc.E_redirect_i)   next_m = ifc.E_redirect_pc_i;
        else if (ifc.D_stall_i) next_m = pc_m;
        else if (pred_m)        next_m = ifc.F_jmp_i;
        else                    next_m = pc_m + 32'd4;
        @(posedge clk);
        #1;
        pc_m = next_m;
        if (ifc.E_redirect_i) mis_m = mis_m + 32'd1;
        if (ifc.E_branch_valid_i) begin
            k = idx_of(ifc.E_branch_pc_i);
            if (ifc.E_branch_taken_i) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
            else                      bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
        end
    endtask

    // driver
    task automatic drive(input logic sel, input logic is_br, input logic [31:0] jmp,
                         input logic stall, input logic red, input logic [31:0] rpc,
                         input logic bv, input logic [31:0] bpc, input logic bt);
        ifc.F_jmp_sel_i       = sel;
        ifc.F_jmp_is_branch_i = is_br;
        ifc.F_jmp_i           = jmp;
        ifc.D_stall_i         = stall;
        ifc.E_redirect_i      = red;
        ifc.E_redirect_pc_i   = rpc;
        ifc.E_branch_valid_i  = bv;
        ifc.E_branch_pc_i     = bpc;
        ifc.E_branch_taken_i  = bt;
        step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        drive(0, 0, 0, 0, 1, pc, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] bpc, input logic taken);
        drive(0, 0, 0, 0, 0, 0, 1, bpc, taken);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        ifc.F_jmp_sel_i = 0; ifc.F_jmp_is_branch_i = 0; ifc.F_jmp_i = 0;
        ifc.D_stall_i = 0; ifc.E_redirect_i = 0; ifc.E_redirect_pc_i = 0;
        ifc.E_branch_valid_i = 0; ifc.E_branch_pc_i = 0; ifc.E_branch_taken_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",  ifc.F_PC_o, RST_PC);
        chk("rst_mis", ifc.mispredict_cnt_o, 32'd0);
        rst_n = 1'b1;

        // sequential fetch 0x8000_0000, _04, _08, _0c, arriving at _10
        repeat (4) idle();

        // jal at 0x8000_0010 -> 0x8000_0100
        drive(1, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
        chk("jal_target", ifc.F_PC_o, 32'h8000_0100);

        // untrained branch at 0x8000_0020 falls through
        redirect_to(32'h8000_0020);
        drive(1, 1, 32'h8000_0300, 0, 0, 0, 0, 0, 0);
        chk("br_untrained", ifc.F_PC_o, 32'h8000_0024);

        // two taken updates, then the same branch predicts taken
        train(32'h8000_0020, 1);
        train(32'h8000_0020, 1);
        redirect_to(32'h8000_0020);
        drive(1, 1, 32'h8000_0300, 0, 0, 0, 0, 0, 0);
        chk("br_trained", ifc.F_PC_o, 32'h8000_0300);

        // stall and redirect in the same cycle: redirect wins
        drive(1, 0, 32'h8000_0500, 1, 1, 32'h8000_0200, 0, 0, 0);
        chk("stall_redirect", ifc.F_PC_o, 32'h8000_0200);

        // stall alone holds PC while the table still trains
        drive(1, 0, 32'h8000_0500, 1, 0, 0, 1, 32'h8000_0040, 1);
        drive(0, 0, 0, 1, 0, 0, 1, 32'h8000_0040, 1);
        chk("stall_hold", ifc.F_PC_o, 32'h8000_0200);

        // five taken then one not-taken on index of 0x8000_0040: 1->..->3->2
        repeat (3) train(32'h8000_0040, 1);
        train(32'h8000_0040, 0);
        redirect_to(32'h8000_0040);
        drive(1, 1, 32'h8000_0700, 0, 0, 0, 0, 0, 0);
        chk("sat_still_taken", ifc.F_PC_o, 32'h8000_0700);

        // same-cycle lookup and update on a weak-NT index: no bypass
        redirect_to(32'h8000_0084);
        drive(1, 1, 32'h8000_0900, 0, 0, 0, 1, 32'h8000_0084, 1);
        chk("no_bypass", ifc.F_PC_o, 32'h8000_0088);
        redirect_to(32'h8000_0084);
        drive(1, 1, 32'h8000_0900, 0, 0, 0, 0, 0, 0);
        chk("after_update", ifc.F_PC_o, 32'h8000_0900);

        // PC+4 wraps at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        idle();
        chk("wrap", ifc.F_PC_o, 32'h0000_0000);
        idle();

        // asynchronous reset mid-run clears PC, count and table
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",  ifc.F_PC_o, RST_PC);
        chk("async_rst_mis", ifc.mispredict_cnt_o, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // trained index of 0x8000_0040 is back to weak-NT
        redirect_to(32'h8000_0040);
        drive(1, 1, 32'h8000_0700, 0, 0, 0, 0, 0, 0);
        chk("table_cleared", ifc.F_PC_o, 32'h8000_0044);

        // random traffic over a small address window so indices collide
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) == 1,
                  RST_PC + 32'(4 * $urandom_range(0, 63)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  RST_PC + 32'(4 * $urandom_range(0, 63)),
                  $urandom_range(0, 2) == 0,
                  RST_PC + 32'(4 * $urandom_range(0, 63)),
                  $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
